// File: rtl/i2s_pkg.sv
// Shared types for the I2S frame path: sample/frame layout, assembler states
// and the saturating counter helper used by the optional error counters.
package i2s_pkg;

    localparam int SAMPLE_W = 24;
    localparam int CNT_W    = 16;

    typedef logic [SAMPLE_W-1:0] sample_t;

    typedef struct packed {
        sample_t left;
        sample_t right;
    } stereo_frame_t;

    typedef enum logic [0:0] {
        WAIT_L = 1'b0,
        HAVE_L = 1'b1
    } asm_state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/i2s_frame_fifo.sv
// Synchronous stereo-frame FIFO with wrap-bit pointers; a push into a full
// FIFO is only accepted when a pop frees a slot on the same edge.
module i2s_frame_fifo
    import i2s_pkg::*;
#(
    parameter int WIDTH = $bits(stereo_frame_t),
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             drop_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      wr_ptr_d;
    logic [AW:0]      rd_ptr_q;
    logic [AW:0]      rd_ptr_d;
    logic             empty;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty;
    assign do_push = push_i && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the head is masked to zero whenever empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

    assign head_o  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign full_o  = full;
    assign empty_o = empty;
    assign drop_o  = push_i && !do_push;

endmodule

// File: rtl/i2s_frame_assembler.sv
// Pairs left/right I2S words into stereo frames, buffers them and flags order
// errors and overflow. Define I2S_FRAME_ASSEMBLER_ERR_CNT_EN for error counters.
module i2s_frame_assembler
    import i2s_pkg::*;
#(
    parameter int BITS_PRECISION = SAMPLE_W,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [BITS_PRECISION-1:0] data_in,
    input  logic                      left_rightn,
    input  logic                      data_en,
    output logic [BITS_PRECISION-1:0] frame_left,
    output logic [BITS_PRECISION-1:0] frame_right,
    output logic                      frame_valid,
    input  logic                      frame_ready,
    output logic                      seq_err,
    output logic                      overflow,
    input  logic                      clear_flags
`ifdef I2S_FRAME_ASSEMBLER_ERR_CNT_EN
    ,
    output logic [CNT_W-1:0]          seq_err_cnt,
    output logic [CNT_W-1:0]          ovf_cnt
`endif
);

    localparam int FW = 2 * BITS_PRECISION;

    asm_state_t                state_q;
    asm_state_t                state_d;
    logic [BITS_PRECISION-1:0] left_q;
    logic [BITS_PRECISION-1:0] left_d;
    logic                      seq_err_q;
    logic                      seq_err_d;
    logic                      overflow_q;
    logic                      overflow_d;
    logic                      push;
    logic                      seq_evt;
    logic                      ovf_evt;
    logic [FW-1:0]             head;
    logic                      fifo_full;
    logic                      fifo_empty;

    always_comb begin
        state_d = state_q;
        left_d  = left_q;
        push    = 1'b0;
        seq_evt = 1'b0;
        if (data_en) begin
            case (state_q)
                WAIT_L: begin
                    if (left_rightn) begin
                        left_d  = data_in;
                        state_d = HAVE_L;
                    end else begin
                        seq_evt = 1'b1;
                    end
                end
                HAVE_L: begin
                    if (left_rightn) begin
                        left_d  = data_in;
                        seq_evt = 1'b1;
                    end else begin
                        push    = 1'b1;
                        state_d = WAIT_L;
                    end
                end
                default: state_d = WAIT_L;
            endcase
        end
    end

    i2s_frame_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i ({left_q, data_in}),
        .pop_i       (frame_ready),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .drop_o      (ovf_evt)
    );

    // A new error event outranks a coincident clear so no event is lost.
    always_comb begin
        seq_err_d  = seq_err_q;
        overflow_d = overflow_q;
        if (seq_evt) begin
            seq_err_d = 1'b1;
        end else if (clear_flags) begin
            seq_err_d = 1'b0;
        end
        if (ovf_evt) begin
            overflow_d = 1'b1;
        end else if (clear_flags) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= WAIT_L;
            left_q     <= '0;
            seq_err_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            left_q     <= left_d;
            seq_err_q  <= seq_err_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef I2S_FRAME_ASSEMBLER_ERR_CNT_EN
    logic [CNT_W-1:0] seq_cnt_q;
    logic [CNT_W-1:0] seq_cnt_d;
    logic [CNT_W-1:0] ovf_cnt_q;
    logic [CNT_W-1:0] ovf_cnt_d;

    // Clearing and counting on the same edge leaves exactly one event counted.
    always_comb begin
        seq_cnt_d = seq_cnt_q;
        ovf_cnt_d = ovf_cnt_q;
        if (seq_evt) begin
            seq_cnt_d = clear_flags ? CNT_W'(1) : sat_inc(seq_cnt_q);
        end else if (clear_flags) begin
            seq_cnt_d = '0;
        end
        if (ovf_evt) begin
            ovf_cnt_d = clear_flags ? CNT_W'(1) : sat_inc(ovf_cnt_q);
        end else if (clear_flags) begin
            ovf_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_cnt_q <= '0;
            ovf_cnt_q <= '0;
        end else begin
            seq_cnt_q <= seq_cnt_d;
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign seq_err_cnt = seq_cnt_q;
    assign ovf_cnt     = ovf_cnt_q;
`endif

    assign frame_left  = head[FW-1:BITS_PRECISION];
    assign frame_right = head[BITS_PRECISION-1:0];
    assign frame_valid = !fifo_empty;
    assign seq_err     = seq_err_q;
    assign overflow    = overflow_q;

    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_i2s_frame_assembler.sv
// Scoreboard bench for i2s_frame_assembler: directed scenarios plus random
// traffic, checked against a queue-based behavioural model of pairing and buffering.
module tb_i2s_frame_assembler;

    localparam int BP    = 24;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [BP-1:0] data_in = '0;
    logic          left_rightn = 1'b0;
    logic          data_en = 1'b0;
    logic [BP-1:0] frame_left;
    logic [BP-1:0] frame_right;
    logic          frame_valid;
    logic          frame_ready = 1'b0;
    logic          seq_err;
    logic          overflow;
    logic          clear_flags = 1'b0;
`ifdef I2S_FRAME_ASSEMBLER_ERR_CNT_EN
    logic [15:0]   seq_err_cnt;
    logic [15:0]   ovf_cnt;
`endif

    i2s_frame_assembler #(
        .BITS_PRECISION (BP),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_in     (data_in),
        .left_rightn (left_rightn),
        .data_en     (data_en),
        .frame_left  (frame_left),
        .frame_right (frame_right),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .seq_err     (seq_err),
        .overflow    (overflow),
        .clear_flags (clear_flags)
`ifdef I2S_FRAME_ASSEMBLER_ERR_CNT_EN
        ,
        .seq_err_cnt (seq_err_cnt),
        .ovf_cnt     (ovf_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: frames the DUT should hold, pending left word, flags.
    logic [2*BP-1:0] expQ[$];
    int              occ = 0;
    logic            haveL = 1'b0;
    logic [BP-1:0]   heldL = '0;
    logic            expSeq = 1'b0;
    logic            expOvf = 1'b0;
    int              expSeqCnt = 0;
    int              expOvfCnt = 0;

    task automatic compare(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int bumpCnt(input int cnt, input logic evt, input logic clr);
        if (evt) return clr ? 1 : ((cnt == 16'hFFFF) ? cnt : cnt + 1);
        if (clr) return 0;
        return cnt;
    endfunction

    task automatic modelReset();
        expQ.delete();
        occ       = 0;
        haveL     = 1'b0;
        heldL     = '0;
        expSeq    = 1'b0;
        expOvf    = 1'b0;
        expSeqCnt = 0;
        expOvfCnt = 0;
    endtask

    task automatic checkOutput();
        compare("frame_valid", 64'(frame_valid), 64'(occ > 0));
        compare("seq_err", 64'(seq_err), 64'(expSeq));
        compare("overflow", 64'(overflow), 64'(expOvf));
`ifdef I2S_FRAME_ASSEMBLER_ERR_CNT_EN
        compare("seq_err_cnt", 64'(seq_err_cnt), 64'(expSeqCnt));
        compare("ovf_cnt", 64'(ovf_cnt), 64'(expOvfCnt));
`endif
    endtask

    // Drive one cycle, advance the model at the edge, then check #1 later.
    task automatic applyStimulus(input logic en, input logic lr, input logic [BP-1:0] d,
                                 input logic rdy, input logic clr);
        logic popNow;
        logic seqEvt;
        logic ovfEvt;
        logic pushNow;
        data_en     = en;
        left_rightn = lr;
        data_in     = d;
        frame_ready = rdy;
        clear_flags = clr;
        @(posedge clk);
        popNow  = rdy && (occ > 0);
        seqEvt  = 1'b0;
        ovfEvt  = 1'b0;
        pushNow = 1'b0;
        if (en) begin
            if (lr) begin
                if (haveL) seqEvt = 1'b1;
                haveL = 1'b1;
                heldL = d;
            end else if (!haveL) begin
                seqEvt = 1'b1;
            end else begin
                haveL = 1'b0;
                if (occ < DEPTH || popNow) begin
                    expQ.push_back({heldL, d});
                    pushNow = 1'b1;
                end else begin
                    ovfEvt = 1'b1;
                end
            end
        end
        occ = occ - int'(popNow) + int'(pushNow);
        if (seqEvt) expSeq = 1'b1; else if (clr) expSeq = 1'b0;
        if (ovfEvt) expOvf = 1'b1; else if (clr) expOvf = 1'b0;
        expSeqCnt = bumpCnt(expSeqCnt, seqEvt, clr);
        expOvfCnt = bumpCnt(expOvfCnt, ovfEvt, clr);
        #1;
        checkOutput();
    endtask

    task automatic sendWord(input logic lr, input logic [BP-1:0] d, input logic rdy);
        applyStimulus(1'b1, lr, d, rdy, 1'b0);
    endtask

    task automatic idle(input logic rdy, input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, rdy, 1'b0);
    endtask

    task automatic resetCheck();
        #1;
        compare("rst frame_valid", 64'(frame_valid), 64'd0);
        compare("rst frame_left", 64'(frame_left), 64'd0);
        compare("rst frame_right", 64'(frame_right), 64'd0);
        compare("rst seq_err", 64'(seq_err), 64'd0);
        compare("rst overflow", 64'(overflow), 64'd0);
    endtask

    // Monitor: a transfer happens at the next edge whenever valid && ready.
    always @(negedge clk) begin
        if (rst_n && frame_valid && frame_ready) begin
            if (expQ.size() == 0) begin
                compare("unexpected frame", 64'({frame_left, frame_right}), 64'd0);
            end else begin
                logic [2*BP-1:0] e;
                e = expQ.pop_front();
                compare("frame_left", 64'(frame_left), 64'(e[2*BP-1:BP]));
                compare("frame_right", 64'(frame_right), 64'(e[BP-1:0]));
            end
        end
    end

    initial begin
        modelReset();
        resetCheck();
        @(negedge clk);
        rst_n = 1'b1;
        idle(1'b0, 2);

        // Normal pairing
        sendWord(1'b1, 24'h123456, 1'b1);
        sendWord(1'b0, 24'hABCDEF, 1'b1);
        idle(1'b1, 3);

        // Sequence errors: R first, double L, then R
        sendWord(1'b0, 24'h000001, 1'b1);
        sendWord(1'b1, 24'h000010, 1'b1);
        sendWord(1'b1, 24'h000020, 1'b1);
        sendWord(1'b0, 24'h000030, 1'b1);
        idle(1'b1, 3);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1);

        // Overflow: five pairs into a stalled FIFO, then drain
        for (int i = 0; i < 5; i++) begin
            sendWord(1'b1, BP'(24'h100 + i), 1'b0);
            sendWord(1'b0, BP'(24'h200 + i), 1'b0);
        end
        idle(1'b1, 6);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);

        // Full FIFO with a pop on the same edge as the fifth R
        for (int i = 0; i < 4; i++) begin
            sendWord(1'b1, BP'(24'h300 + i), 1'b0);
            sendWord(1'b0, BP'(24'h400 + i), 1'b0);
        end
        sendWord(1'b1, 24'h000305, 1'b0);
        sendWord(1'b0, 24'h000405, 1'b1);
        idle(1'b1, 7);

        // Async reset mid-frame with frames buffered and a flag set
        sendWord(1'b0, 24'h000777, 1'b0);
        sendWord(1'b1, 24'h000001, 1'b0);
        sendWord(1'b0, 24'h000002, 1'b0);
        sendWord(1'b1, 24'h0000AA, 1'b0);
        #2;
        rst_n = 1'b0;
        modelReset();
        resetCheck();
        @(negedge clk);
        rst_n = 1'b1;
        sendWord(1'b0, 24'h0000BB, 1'b1);
        idle(1'b1, 2);

        // Flag clear race: set wins, then a lone clear takes effect
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 24'h000055, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          BP'($urandom), 1'($urandom_range(0, 2) != 0),
                          1'($urandom_range(0, 19) == 0));
        end
        idle(1'b1, DEPTH + 3);
        compare("scoreboard drained", 64'(expQ.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2s_frame_assembler.md
Name: i2s_frame_assembler

Overview:
- Sits directly downstream of the I2S receiver (i2sin).
- Consumes the receiver's per-word strobe (data_en), word (data_in) and channel flag (left_rightn).
- Pairs consecutive left/right words into one stereo frame and buffers frames in a small FIFO.
- Presents frames to the mixer core on a valid/ready handshake and flags channel-sequencing errors and overflow.

Parameters:
- BITS_PRECISION, 24, width of one channel sample; matches the receiver.
- FIFO_DEPTH, 4, number of stereo frames buffered; power of two, >= 2.

Ports:
- clk  in  1  system clock; same domain as the receiver.
- rst_n  in  1  asynchronous, active-low reset.
- data_in  in  BITS_PRECISION  word from the receiver; valid only when data_en=1.
- left_rightn  in  1  channel of the completing word; 1 = left, 0 = right.
- data_en  in  1  one-cycle strobe: a word is complete this cycle.
- frame_left  out  BITS_PRECISION  left sample of the FIFO head.
- frame_right  out  BITS_PRECISION  right sample of the FIFO head.
- frame_valid  out  1  FIFO non-empty.
- frame_ready  in  1  consumer accepts the head when frame_valid=1.
- seq_err  out  1  sticky: channel order violated.
- overflow  out  1  sticky: a complete frame was dropped because the FIFO was full.
- clear_flags  in  1  synchronous clear of the sticky flags (and counters when enabled).

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - FSM = WAIT_L; FIFO empty; left holding register = 0.
  - frame_valid = 0; frame_left and frame_right = 0; seq_err and overflow = 0.
- FSM, evaluated only on cycles with data_en=1:
  - WAIT_L, left word: store in left holding register -> HAVE_L.
  - WAIT_L, right word: drop the word, set seq_err, stay in WAIT_L.
  - HAVE_L, right word: form frame {left holding register, data_in}, push to FIFO -> WAIT_L.
  - HAVE_L, left word: overwrite the left holding register, set seq_err, stay in HAVE_L. The newest left word is kept.
- Push/pop timing:
  - Push occurs in the same clock edge as the data_en cycle.
  - frame_valid rises the cycle after the push (1-cycle latency).
- FIFO and handshake:
  - Pop occurs when frame_valid && frame_ready at the clock edge.
  - Outputs are driven from registered head storage, with no combinational path from inputs.
  - frame_left/frame_right are held stable while frame_valid=1 and frame_ready=0.
- Full boundary:
  - Push when full and no pop in that cycle: drop the frame, set overflow, FIFO unchanged, FSM still -> WAIT_L.
  - Push when full with a simultaneous pop: accepted, count unchanged.
- Empty boundary:
  - Pop when empty is ignored.
  - Simultaneous push and pop while empty: the push is kept, so frame_valid=1 on the next cycle.
- Pointers: read and write pointers are log2(FIFO_DEPTH) bits plus a wrap bit. Full = same index with the wrap bit different.
- Sticky flags:
  - Clear only on clear_flags or reset.
  - If clear_flags coincides with a new error event, the set wins.
- data_en=0 cycles: no state change except FIFO pops.

Optional Feature:
- Macro: I2S_FRAME_ASSEMBLER_ERR_CNT_EN
- Defined:
  - Adds output seq_err_cnt[15:0] and output ovf_cnt[15:0].
  - Each increments on the same events that set the matching sticky flag and saturates at 16'hFFFF.
  - Both are zeroed by reset and by clear_flags; on coincidence, the increment wins and the count becomes 1.
- Undefined: the ports and counters are absent; sticky flags only.

Decomposition:
- Shared package i2s_pkg:
  - Typedef sample_t (logic [BITS_PRECISION-1:0]).
  - Typedef stereo_frame_t (struct: left, right).
  - Enum asm_state_t {WAIT_L, HAVE_L}.
  - Localparam CNT_W = 16.
- One sub-module: i2s_frame_fifo (parameterised synchronous FIFO of stereo_frame_t with push, pop, full, empty). It is reusable on the transmit side.

Test Plan:
- Normal pairing: L=24'h123456 then R=24'hABCDEF, frame_ready=1 -> one frame {123456, ABCDEF}; frame_valid high for 1 cycle, rising 1 cycle after the R strobe; no flags.
- Sequence errors: R=24'h000001 first, then L=24'h000010, L=24'h000020, R=24'h000030 -> seq_err=1 after the first R; single frame {000020, 000030}; with macro enabled, seq_err_cnt=2.
- Overflow: frame_ready=0, 5 L/R pairs with FIFO_DEPTH=4 -> first 4 frames retained in order; 5th dropped; overflow=1. Then frame_ready=1 -> 4 frames drain in order, frame_valid=0 after.
- Full with simultaneous pop: FIFO full, frame_ready=1 on the same cycle as the 5th R strobe -> no overflow; 5th frame delivered after the prior 4.
- Async reset mid-frame: after L=24'h0000AA, assert rst_n=0 with no clk edge -> all outputs immediately 0. After release, R=24'h0000BB -> seq_err=1, no frame pushed.
- Flag clear race: clear_flags=1 on the same cycle as an R-in-WAIT_L strobe -> seq_err remains 1; clear_flags alone next cycle -> seq_err=0.
